block_accumulator: RTL and testbench
====================================

# block_accumulator

Sequential accumulator that sums a stream of `BLOCK_LEN` unsigned input words and presents each block total on a valid/ready output. It sits directly downstream of `ripple_carry_adder`, which it instantiates at `ACC_WIDTH` bits as its adder. It adds the register, control and handshake layer that turns that combinational adder into a streaming datapath stage.

## Interface
Parameters:
- `DATA_WIDTH`, 4, width of each input word; must be ≥1.
- `ACC_WIDTH`, 8, width of accumulator and result; must be ≥ `DATA_WIDTH`.
- `BLOCK_LEN`, 4, number of accepted words per result; must be ≥1.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset: asynchronous, active-low.
- `clear`  in  1  synchronous clear; highest priority after reset.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  block can accept a word this cycle.
- `in_data`  in  `DATA_WIDTH`  unsigned input word.
- `out_valid`  out  1  `out_sum` and `out_overflow` hold a completed block result.
- `out_ready`  in  1  downstream consumes the result this cycle.
- `out_sum`  out  `ACC_WIDTH`  block total, modulo 2^`ACC_WIDTH`.
- `out_overflow`  out  1  at least one addition in the block produced a carry-out.

## Operation
- **State machine.** Two states:
  - ACC: accepting words.
  - HOLD: result pending.
- **Internal registers.**
  - `acc[ACC_WIDTH]`
  - `cnt`, width `$clog2(BLOCK_LEN+1)`
  - `ovf` (sticky)
  - result registers driving `out_sum` / `out_overflow`
- **Adder.**
  - Operands are `acc` and `in_data` zero-extended to `ACC_WIDTH`; `c_in` is tied to 0.
  - The adder's `sum` is the next `acc`; its `carry` ORs into `ovf`.
- **Ready.** `in_ready` = (state == ACC) && !`clear`.
- **Accept.** An accept occurs when `in_valid` && `in_ready`.
- **ACC state, accept with `cnt` < `BLOCK_LEN`-1:**
  - `acc` ← sum
  - `ovf` ← `ovf` | carry
  - `cnt` ← `cnt`+1
- **ACC state, accept with `cnt` == `BLOCK_LEN`-1:**
  - `out_sum` ← sum
  - `out_overflow` ← `ovf` | carry
  - `acc`, `cnt`, `ovf` ← 0
  - `out_valid` ← 1; go to HOLD.
- **ACC state, no accept:** all state holds. Bubbles on `in_valid` are allowed; `cnt` counts accepts only.
- **HOLD state:**
  - `in_ready` = 0 and `in_data` is ignored.
  - `out_sum` and `out_overflow` are stable until the handshake.
  - On `out_valid` && `out_ready`: `out_valid` ← 0; go to ACC.
- **`clear` = 1 (any state):**
  - `acc`, `cnt`, `ovf` ← 0
  - `out_valid` ← 0, discarding any pending result
  - `out_sum`, `out_overflow` ← 0
  - state ← ACC
  - No accept occurs that cycle.
- **`BLOCK_LEN` = 1:** every accepted word produces a result, which includes its own carry.

## Timing
- **Reset values** (while `rst_n` = 0, applied immediately and asynchronously):
  - state = ACC
  - `acc`, `cnt`, `ovf` = 0
  - `out_valid` = 0, `out_sum` = 0, `out_overflow` = 0
  - `in_ready` = 1, but no accept is recognised while `rst_n` = 0.
- **Reset mid-block or mid-HOLD:** partial sums and pending results are lost; the first accept after reset deassertion starts a new block.
- **Latency:** `out_valid` rises the cycle after the final accept.
- **Throughput:** at best one result every `BLOCK_LEN`+1 cycles. The HOLD state lasts at least one cycle, and `in_ready` is low for that cycle.
- **Handshake:** the output follows valid/ready rules. `out_valid` never drops without a handshake, `clear`, or reset.
- **Inputs:** `out_ready` is ignored while `out_valid` = 0. `in_valid` is ignored in HOLD.
- **Combinational paths:**
  - `in_ready` is combinational from state and `clear`.
  - The adder path (`acc` → adder → `acc`) is combinational within one cycle.
  - No combinational path exists from `out_ready` to any output.

## Test plan
Default parameters unless noted.
- **Back-to-back:** `in_data` 1,2,3,4 on consecutive cycles, `out_ready`=1 → `out_valid` one cycle after the 4th accept, `out_sum`=10, `out_overflow`=0. `in_ready` is low exactly 1 cycle, then high; a second block 5,5,5,5 → `out_sum`=20.
- **Overflow, `ACC_WIDTH`=5:** 15,15,15,15 → `out_sum`=28 (60 mod 32), `out_overflow`=1. The next block 1,1,1,1 → `out_sum`=4, `out_overflow`=0, so the sticky flag does not leak across blocks.
- **Backpressure:** after block 1,2,3,4, hold `out_ready`=0 for 5 cycles while driving `in_valid`=1, `in_data`=7 → `out_valid` stays 1, `out_sum` stays 10, `in_ready`=0, and no 7 is accumulated. After `out_ready`=1, the next block starts clean.
- **Bubbles:** 2,0-gap,3,gap,gap,4,5 with `in_valid` toggling → `out_sum`=14; the result appears only after the 4th accept.
- **Clear:** accept 5,6, pulse `clear`, then accept 1,1,1,1 → `out_sum`=4. Also `clear` during HOLD with `out_ready`=0 → `out_valid` drops the next cycle and `out_sum`=0.
- **Reset:** assert `rst_n`=0 mid-block after 9,9 → all outputs read 0 immediately, without waiting for a clock edge. After release, 1,2,3,4 → `out_sum`=10. With `BLOCK_LEN`=1, a stream of 3s → `out_sum`=3 every 2 cycles.

Source files
------------

// File: rtl/block_accumulator.sv
// Streaming block accumulator: sums BLOCK_LEN words through a ripple-carry adder
// and presents each block total, with a sticky carry flag, on a valid/ready output.

module ripple_carry_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic c;

  // Carry ripples through a local variable so the chain stays a single comb process.
  always_comb begin
    c   = c_in;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    carry = c;
  end

endmodule

module block_accumulator #(
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 8,
  parameter int BLOCK_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic                  out_overflow
);

  localparam int CNT_W = $clog2(BLOCK_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

  typedef enum logic {ACC, HOLD} state_t;

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] res_sum_q, res_sum_d;
  logic                 res_ovf_q, res_ovf_d;

  logic [ACC_WIDTH-1:0] add_sum;
  logic                 add_carry;
  logic                 accept;

  ripple_carry_adder #(.WIDTH(ACC_WIDTH)) u_adder (
    .a     (acc_q),
    .b     (ACC_WIDTH'(in_data)),
    .c_in  (1'b0),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign in_ready     = (state_q == ACC) && !clear;
  assign accept       = in_valid && in_ready;
  assign out_valid    = (state_q == HOLD);
  assign out_sum      = res_sum_q;
  assign out_overflow = res_ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      res_sum_q <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      res_sum_q <= res_sum_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  // Clear overrides everything, including a pending result in HOLD.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_sum_d = res_sum_q;
    res_ovf_d = res_ovf_q;
    if (clear) begin
      state_d   = ACC;
      acc_d     = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      res_sum_d = '0;
      res_ovf_d = 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (accept) begin
            if (cnt_q == LAST_CNT) begin
              res_sum_d = add_sum;
              res_ovf_d = ovf_q | add_carry;
              acc_d     = '0;
              cnt_d     = '0;
              ovf_d     = 1'b0;
              state_d   = HOLD;
            end else begin
              acc_d = add_sum;
              ovf_d = ovf_q | add_carry;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) state_d = ACC;
        end
        default: state_d = ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_block_accumulator.sv
// Directed bench for block_accumulator: a per-cycle vector table on the default
// configuration plus hand sequences for reset, 5-bit overflow and BLOCK_LEN=1.

module tb_block_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic       a_clear, a_in_valid, a_out_ready, a_in_ready, a_out_valid, a_out_overflow;
  logic [3:0] a_in_data;
  logic [7:0] a_out_sum;

  logic       b_clear, b_in_valid, b_out_ready, b_in_ready, b_out_valid, b_out_overflow;
  logic [3:0] b_in_data;
  logic [4:0] b_out_sum;

  logic       c_clear, c_in_valid, c_out_ready, c_in_ready, c_out_valid, c_out_overflow;
  logic [3:0] c_in_data;
  logic [7:0] c_out_sum;

  block_accumulator dut_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_overflow(a_out_overflow)
  );

  block_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(5), .BLOCK_LEN(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_overflow(b_out_overflow)
  );

  block_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(8), .BLOCK_LEN(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .clear(c_clear), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_sum(c_out_sum), .out_overflow(c_out_overflow)
  );

  typedef struct packed {
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_ready;
    logic       clear;
    logic       exp_ready;
    logic       exp_valid;
    logic [7:0] exp_sum;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];
  int   nVectors = 0;
  int   nMiscompares = 0;

  task automatic addVec(input logic iv, input logic [3:0] d, input logic ordy, input logic clr,
                        input logic er, input logic ev, input logic [7:0] es, input logic eo);
    vec_t v;
    v = '{in_valid: iv, in_data: d, out_ready: ordy, clear: clr,
          exp_ready: er, exp_valid: ev, exp_sum: es, exp_ovf: eo};
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // in_ready is sampled before the edge it governs; registered outputs just after it.
  task automatic applyStimulus(input int idx, input vec_t v);
    @(negedge clk);
    a_in_valid  = v.in_valid;
    a_in_data   = v.in_data;
    a_out_ready = v.out_ready;
    a_clear     = v.clear;
    #1;
    checkOutput($sformatf("v%0d in_ready", idx), int'(a_in_ready), int'(v.exp_ready));
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d out_valid", idx), int'(a_out_valid), int'(v.exp_valid));
    checkOutput($sformatf("v%0d out_sum", idx), int'(a_out_sum), int'(v.exp_sum));
    checkOutput($sformatf("v%0d out_overflow", idx), int'(a_out_overflow), int'(v.exp_ovf));
  endtask

  task automatic driveA(input logic iv, input logic [3:0] d, input logic ordy);
    @(negedge clk);
    a_in_valid = iv; a_in_data = d; a_out_ready = ordy; a_clear = 1'b0;
  endtask

  task automatic driveB(input logic iv, input logic [3:0] d, input logic ordy);
    @(negedge clk);
    b_in_valid = iv; b_in_data = d; b_out_ready = ordy;
  endtask

  task automatic runBlockB(input string name, input logic [3:0] d0, input logic [3:0] d1,
                           input logic [3:0] d2, input logic [3:0] d3,
                           input int es, input int eo);
    driveB(1'b1, d0, 1'b1);
    driveB(1'b1, d1, 1'b1);
    driveB(1'b1, d2, 1'b1);
    driveB(1'b1, d3, 1'b1);
    @(posedge clk); #1;
    checkOutput({name, " out_valid"}, int'(b_out_valid), 1);
    checkOutput({name, " out_sum"}, int'(b_out_sum), es);
    checkOutput({name, " out_overflow"}, int'(b_out_overflow), eo);
    driveB(1'b0, 4'd0, 1'b1);
    @(posedge clk); #1;
    checkOutput({name, " handshake"}, int'(b_out_valid), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_clear = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_clear = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    c_clear = 0; c_in_valid = 0; c_in_data = 0; c_out_ready = 0;

    #2;
    checkOutput("reset in_ready", int'(a_in_ready), 1);
    checkOutput("reset out_valid", int'(a_out_valid), 0);
    checkOutput("reset out_sum", int'(a_out_sum), 0);
    checkOutput("reset out_overflow", int'(a_out_overflow), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back blocks; in_ready drops for exactly the HOLD cycle.
    addVec(1, 1, 1, 0, 1, 0, 0, 0);
    addVec(1, 2, 1, 0, 1, 0, 0, 0);
    addVec(1, 3, 1, 0, 1, 0, 0, 0);
    addVec(1, 4, 1, 0, 1, 1, 10, 0);
    addVec(1, 5, 1, 0, 0, 0, 10, 0);
    addVec(1, 5, 1, 0, 1, 0, 10, 0);
    addVec(1, 5, 1, 0, 1, 0, 10, 0);
    addVec(1, 5, 1, 0, 1, 0, 10, 0);
    addVec(1, 5, 1, 0, 1, 1, 20, 0);
    addVec(0, 0, 1, 0, 0, 0, 20, 0);
    // Backpressure: 7s offered during HOLD must not be accumulated.
    addVec(1, 1, 0, 0, 1, 0, 20, 0);
    addVec(1, 2, 0, 0, 1, 0, 20, 0);
    addVec(1, 3, 0, 0, 1, 0, 20, 0);
    addVec(1, 4, 0, 0, 1, 1, 10, 0);
    for (int k = 0; k < 5; k++) addVec(1, 7, 0, 0, 0, 1, 10, 0);
    addVec(1, 7, 1, 0, 0, 0, 10, 0);
    // Bubbles on in_valid: 2,3,4,5 accepted with gaps.
    addVec(1, 2, 1, 0, 1, 0, 10, 0);
    addVec(0, 9, 1, 0, 1, 0, 10, 0);
    addVec(1, 3, 1, 0, 1, 0, 10, 0);
    addVec(0, 0, 1, 0, 1, 0, 10, 0);
    addVec(0, 0, 1, 0, 1, 0, 10, 0);
    addVec(1, 4, 1, 0, 1, 0, 10, 0);
    addVec(1, 5, 1, 0, 1, 1, 14, 0);
    addVec(0, 0, 1, 0, 0, 0, 14, 0);
    // Clear mid-block, then clear while a result is held.
    addVec(1, 5, 1, 0, 1, 0, 14, 0);
    addVec(1, 6, 1, 0, 1, 0, 14, 0);
    addVec(1, 9, 1, 1, 0, 0, 0, 0);
    addVec(1, 1, 1, 0, 1, 0, 0, 0);
    addVec(1, 1, 1, 0, 1, 0, 0, 0);
    addVec(1, 1, 1, 0, 1, 0, 0, 0);
    addVec(1, 1, 1, 0, 1, 1, 4, 0);
    addVec(0, 0, 0, 0, 0, 1, 4, 0);
    addVec(0, 0, 0, 1, 0, 0, 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 0, 0);

    foreach (vecs[i]) applyStimulus(i, vecs[i]);

    // Asynchronous reset while a result is held.
    for (int d = 1; d <= 4; d++) driveA(1'b1, 4'(d), 1'b0);
    @(posedge clk); #1;
    checkOutput("pre-reset out_sum", int'(a_out_sum), 10);
    #2;
    rst_n = 1'b0;
    a_in_valid = 1'b0;
    #1;
    checkOutput("async reset out_valid", int'(a_out_valid), 0);
    checkOutput("async reset out_sum", int'(a_out_sum), 0);
    checkOutput("async reset in_ready", int'(a_in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-block after 9,9 must discard the partial sum.
    driveA(1'b1, 4'd9, 1'b1);
    driveA(1'b1, 4'd9, 1'b1);
    @(negedge clk);
    a_in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid-block reset out_valid", int'(a_out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int d = 1; d <= 4; d++) driveA(1'b1, 4'(d), 1'b1);
    @(posedge clk); #1;
    checkOutput("post-reset out_valid", int'(a_out_valid), 1);
    checkOutput("post-reset out_sum", int'(a_out_sum), 10);
    driveA(1'b0, 4'd0, 1'b1);

    // 5-bit accumulator: wrap, sticky flag, and no leak across blocks.
    runBlockB("ovf 15x4", 4'd15, 4'd15, 4'd15, 4'd15, 28, 1);
    runBlockB("ovf 1x4", 4'd1, 4'd1, 4'd1, 4'd1, 4, 0);
    runBlockB("ovf sticky", 4'd15, 4'd15, 4'd15, 4'd0, 13, 1);

    // BLOCK_LEN=1: a continuous stream of 3s yields a result every other cycle.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      c_in_valid = 1'b1; c_in_data = 4'd3; c_out_ready = 1'b1;
      #1;
      checkOutput($sformatf("len1 c%0d in_ready", k), int'(c_in_ready), (k % 2 == 0) ? 1 : 0);
      @(posedge clk); #1;
      checkOutput($sformatf("len1 c%0d out_valid", k), int'(c_out_valid), (k % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("len1 c%0d out_sum", k), int'(c_out_sum), 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
